// File: rtl/spectrum_bar_mapper_if.sv
// Stream interface carrying post-FFT beats into the bar mapper.
//   s_tvalid    : beat valid (no backpressure, every valid beat is consumed)
//   s_tlast     : last beat of a frame
//   s_tdata     : {im, re}, each DATA_WIDTH-bit signed
//   s_tuser_idx : FFT bin index of the beat
interface spectrum_bar_mapper_if #(
   parameter int DATA_WIDTH = 16,
   parameter int IW         = 10
);
   logic                    s_tvalid;
   logic                    s_tlast;
   logic [2*DATA_WIDTH-1:0] s_tdata;
   logic [IW-1:0]           s_tuser_idx;

   modport master (output s_tvalid, s_tlast, s_tdata, s_tuser_idx);
   modport slave  (input  s_tvalid, s_tlast, s_tdata, s_tuser_idx);
endinterface

// File: rtl/spectrum_bar_mapper.sv
// Streaming post-FFT bar mapper: |X|^2 -> log2 height -> max-reduce bins into
// bars, commits whole frames into a display buffer with fall-off decay and a
// peak-hold track.
//   clk_50mhz, reset_n : clock, async active-low reset
//   s_axis             : beat stream (slave side)
//   rd_addr            : display read address
//   rd_height/rd_peak  : committed height/peak at rd_addr, 1-cycle latency
//   frame_done         : pulse per committed frame
//   frame_err          : pulse per aborted (out-of-order) frame
module spectrum_bar_mapper #(
   parameter int FFT_POINTS        = 1024,
   parameter int DATA_WIDTH        = 16,
   parameter int NUM_BARS          = 32,
   parameter int BIN_OFFSET        = 512,
   parameter int BINS_PER_BAR      = 16,
   parameter int HEIGHT_LEVELS     = 16,
   parameter int LOG_FLOOR         = 16,
   parameter int DECAY_FRAMES      = 2,
   parameter int PEAK_DECAY_FRAMES = 16,
   parameter bit REVERSE_BARS      = 1'b1,
   localparam int IW = $clog2(FFT_POINTS),
   localparam int BW = $clog2(NUM_BARS),
   localparam int HW = $clog2(HEIGHT_LEVELS + 1)
) (
   input  logic                           clk_50mhz,
   input  logic                           reset_n,
   spectrum_bar_mapper_if.slave           s_axis,
   input  logic [BW-1:0]                  rd_addr,
   output logic [HW-1:0]                  rd_height,
   output logic [HW-1:0]                  rd_peak,
   output logic                           frame_done,
   output logic                           frame_err
);
   localparam int STAGES = 3;
   localparam int PW  = 2 * DATA_WIDTH;
   localparam int MW  = 2 * DATA_WIDTH + 1;
   localparam int DCW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
   localparam int PCW = (PEAK_DECAY_FRAMES > 1) ? $clog2(PEAK_DECAY_FRAMES) : 1;

   // pipeline: [0] is the live input, [k] is the output of stage k
   logic [STAGES:0]         vld_pipe, last_pipe;
   logic [IW-1:0]           idx1, idx2, idx3;
   logic signed [PW-1:0]    sq_re, sq_im;
   logic [MW-1:0]           mag2;
   logic [HW-1:0]           h3;
   logic [BW-1:0]           addr3;
   logic                    inr3;

   logic signed [DATA_WIDTH-1:0] re0, im0;
   assign re0 = s_axis.s_tdata[DATA_WIDTH-1:0];
   assign im0 = s_axis.s_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
   assign vld_pipe[0]  = s_axis.s_tvalid;
   assign last_pipe[0] = s_axis.s_tlast;

   // frame state
   logic [NUM_BARS-1:0][HW-1:0] work, work_upd, disp, disp_nxt, peak, peak_nxt;
   logic [DCW-1:0]          dec_cnt;
   logic [PCW-1:0]          pk_cnt;
   logic [IW-1:0]           prev_idx;
   logic                    have_prev, aborted;

   // S3 height: position of the leading one, offset by the log floor, clamped
   int            msb, lvl, off, bar;
   logic [HW-1:0] h_calc;
   logic [BW-1:0] addr_calc;
   logic          inr_calc;
   always_comb begin
      msb = 0;
      for (int i = 0; i < MW; i++)
         if (mag2[i]) msb = i;
      lvl    = msb + 1 - LOG_FLOOR;
      h_calc = '0;
      if (mag2 != '0) begin
         if (lvl >= HEIGHT_LEVELS) h_calc = HW'(HEIGHT_LEVELS);
         else if (lvl > 0)         h_calc = HW'(lvl);
      end
      off       = int'(idx2) - BIN_OFFSET;
      inr_calc  = (off >= 0) && (off < NUM_BARS * BINS_PER_BAR);
      bar       = off / BINS_PER_BAR;
      addr_calc = REVERSE_BARS ? BW'(NUM_BARS - 1 - bar) : BW'(bar);
   end

   // the offending beat itself is already dropped, not just its successors
   logic bad, ab_now;
   assign bad    = vld_pipe[3] && have_prev && (idx3 <= prev_idx);
   assign ab_now = aborted || bad;

   always_comb begin
      work_upd = work;
      if (vld_pipe[3] && !ab_now && inr3 && (h3 > work[addr3]))
         work_upd[addr3] = h3;
   end

   // per-bar commit: decayed display vs. frame max, then peak hold
   for (genvar b = 0; b < NUM_BARS; b++) begin : g_bar
      logic [HW-1:0] dh, pk, nd;
      assign dh = (dec_cnt == '0 && disp[b] != '0) ? disp[b] - 1'b1 : disp[b];
      assign pk = (pk_cnt == '0 && peak[b] != '0) ? peak[b] - 1'b1 : peak[b];
      assign nd = (work_upd[b] > dh) ? work_upd[b] : dh;
      assign disp_nxt[b] = nd;
      assign peak_nxt[b] = (nd > pk) ? nd : pk;
   end

   always_ff @(posedge clk_50mhz or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe[STAGES:1]  <= '0;
         last_pipe[STAGES:1] <= '0;
         idx1 <= '0; idx2 <= '0; idx3 <= '0;
         sq_re <= '0; sq_im <= '0; mag2 <= '0;
         h3 <= '0; addr3 <= '0; inr3 <= 1'b0;
         work <= '0; disp <= '0; peak <= '0;
         dec_cnt <= '0; pk_cnt <= '0;
         prev_idx <= '0; have_prev <= 1'b0; aborted <= 1'b0;
         rd_height <= '0; rd_peak <= '0;
         frame_done <= 1'b0; frame_err <= 1'b0;
      end else begin
         vld_pipe[STAGES:1]  <= vld_pipe[STAGES-1:0];
         last_pipe[STAGES:1] <= last_pipe[STAGES-1:0];
         idx1  <= s_axis.s_tuser_idx;
         idx2  <= idx1;
         idx3  <= idx2;
         sq_re <= re0 * re0;
         sq_im <= im0 * im0;
         // squares are non-negative, so the unsigned view is exact
         mag2  <= MW'($unsigned(sq_re)) + MW'($unsigned(sq_im));
         h3    <= h_calc;
         addr3 <= addr_calc;
         inr3  <= inr_calc;

         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         if (vld_pipe[3]) begin
            if (last_pipe[3]) begin
               work      <= '0;
               aborted   <= 1'b0;
               have_prev <= 1'b0;
               if (ab_now) begin
                  frame_err <= 1'b1;
               end else begin
                  disp       <= disp_nxt;
                  peak       <= peak_nxt;
                  frame_done <= 1'b1;
                  dec_cnt <= (dec_cnt == DCW'(DECAY_FRAMES - 1)) ? '0 : dec_cnt + 1'b1;
                  pk_cnt  <= (pk_cnt == PCW'(PEAK_DECAY_FRAMES - 1)) ? '0 : pk_cnt + 1'b1;
               end
            end else if (ab_now) begin
               aborted <= 1'b1;
            end else begin
               work      <= work_upd;
               prev_idx  <= idx3;
               have_prev <= 1'b1;
            end
         end

         rd_height <= disp[rd_addr];
         rd_peak   <= peak[rd_addr];
      end
   end
endmodule

// File: tb/tb_spectrum_bar_mapper.sv
module tb_spectrum_bar_mapper;
   logic       clk_50mhz = 1'b0;
   logic       reset_n   = 1'b0;
   logic [4:0] rd_addr   = '0;
   logic [4:0] rd_height, rd_peak;
   logic       frame_done, frame_err;

   int vectors = 0;
   int miscmp  = 0;

   spectrum_bar_mapper_if #(.DATA_WIDTH(16), .IW(10)) bus ();

   spectrum_bar_mapper dut (
      .clk_50mhz (clk_50mhz),
      .reset_n   (reset_n),
      .s_axis    (bus),
      .rd_addr   (rd_addr),
      .rd_height (rd_height),
      .rd_peak   (rd_peak),
      .frame_done(frame_done),
      .frame_err (frame_err)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   // reference state
   int m_disp[32];
   int m_peak[32];
   int m_commits = 0;
   int re_a[1024];
   int im_a[1024];
   int q_idx[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscmp++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int h_of(input int re, input int im);
      longint m;
      int l;
      m = longint'(re) * re + longint'(im) * im;
      if (m == 0) return 0;
      l = 0;
      while ((m >> (l + 1)) != 0) l++;
      l = l + 1 - 16;
      if (l < 0) return 0;
      if (l > 16) return 16;
      return l;
   endfunction

   function automatic int addr_of(input int idx);
      if (idx < 512 || idx >= 1024) return -1;
      return 31 - (idx - 512) / 16;
   endfunction

   function automatic void clear_data();
      for (int i = 0; i < 1024; i++) begin re_a[i] = 0; im_a[i] = 0; end
      q_idx.delete();
   endfunction

   function automatic void full_order(input int dup);
      for (int i = 0; i < 1024; i++) begin
         q_idx.push_back(i);
         if (i == dup) q_idx.push_back(i);
      end
   endfunction

   function automatic void model_reset();
      for (int b = 0; b < 32; b++) begin m_disp[b] = 0; m_peak[b] = 0; end
      m_commits = 0;
   endfunction

   task automatic drive_beat(input int idx, input bit last);
      @(negedge clk_50mhz);
      bus.s_tvalid    = 1'b1;
      bus.s_tlast     = last;
      bus.s_tdata     = {16'(im_a[idx]), 16'(re_a[idx])};
      bus.s_tuser_idx = 10'(idx);
   endtask

   task automatic read_all(input string tag);
      for (int a = 0; a < 32; a++) begin
         @(negedge clk_50mhz);
         rd_addr = 5'(a);
         @(posedge clk_50mhz); #1;
         chk({tag, "_height"}, 32'(rd_height), 32'(m_disp[31 - a] >= 0 ? m_disp[a] : 0));
         chk({tag, "_peak"},   32'(rd_peak),   32'(m_peak[a]));
      end
   endtask

   // sends q_idx as one frame, checks pulse timing, commits the model, reads back
   task automatic run_frame(input string tag);
      int  work[32];
      int  prev, a, dh, pk;
      bit  ab;
      ab = 0; prev = -1;
      for (int b = 0; b < 32; b++) work[b] = 0;
      foreach (q_idx[i]) begin
         if (prev >= 0 && q_idx[i] <= prev) ab = 1;
         prev = q_idx[i];
         a = addr_of(q_idx[i]);
         if (!ab && a >= 0 && h_of(re_a[q_idx[i]], im_a[q_idx[i]]) > work[a])
            work[a] = h_of(re_a[q_idx[i]], im_a[q_idx[i]]);
      end
      foreach (q_idx[i]) drive_beat(q_idx[i], i == q_idx.size() - 1);
      @(posedge clk_50mhz); #1;
      bus.s_tvalid = 1'b0;
      bus.s_tlast  = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk_50mhz); #1;
         chk({tag, "_done"}, 32'(frame_done), 32'(!ab && k == 3));
         chk({tag, "_err"},  32'(frame_err),  32'(ab && k == 3));
      end
      if (!ab) begin
         for (int b = 0; b < 32; b++) begin
            dh = (m_commits % 2 == 0)  ? ((m_disp[b] > 0) ? m_disp[b] - 1 : 0) : m_disp[b];
            pk = (m_commits % 16 == 0) ? ((m_peak[b] > 0) ? m_peak[b] - 1 : 0) : m_peak[b];
            m_disp[b] = (work[b] > dh) ? work[b] : dh;
            m_peak[b] = (m_disp[b] > pk) ? m_disp[b] : pk;
         end
         m_commits++;
      end
      read_all(tag);
   endtask

   function automatic void random_data();
      logic signed [15:0] t;
      clear_data();
      for (int i = 0; i < 1024; i++) begin
         t = 16'($urandom); re_a[i] = int'(t >>> $urandom_range(0, 15));
         t = 16'($urandom); im_a[i] = int'(t >>> $urandom_range(0, 15));
      end
   endfunction

   initial begin
      bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0; bus.s_tdata = '0; bus.s_tuser_idx = '0;
      model_reset();

      // reset state
      repeat (3) @(posedge clk_50mhz);
      #1;
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_err",  32'(frame_err),  32'd0);
      @(negedge clk_50mhz); reset_n = 1'b1;
      read_all("rst");

      // weak bin and strong bin in bar 0 (addr 31)
      clear_data(); re_a[512] = 16'h0100; re_a[527] = 16'h7FFF; full_order(-1);
      run_frame("frA");

      // full-scale clamp at addr 0, below-floor bin at addr 20
      clear_data(); re_a[1008] = -32768; im_a[1008] = -32768; re_a[700] = 1; full_order(-1);
      run_frame("frB");

      // height 10 on addr 5, then zero frames to exercise fall-off
      clear_data(); re_a[928] = 5793; full_order(-1);
      run_frame("frC");
      for (int f = 0; f < 4; f++) begin
         clear_data(); full_order(-1);
         run_frame("decay");
      end

      // repeated index aborts the frame, next clean frame commits
      clear_data(); re_a[928] = 16'h7FFF; re_a[1000] = 16'h4000; full_order(600);
      run_frame("abort");
      random_data(); full_order(-1);
      run_frame("post_abort");

      // random sparse frames with gaps in the bin index
      for (int f = 0; f < 4; f++) begin
         random_data();
         for (int i = $urandom_range(0, 3); i < 1024; i += $urandom_range(1, 3))
            q_idx.push_back(i);
         run_frame("rand");
      end

      // reset in the middle of a frame
      random_data();
      for (int i = 0; i <= 800; i++) drive_beat(i, 1'b0);
      @(negedge clk_50mhz);
      reset_n = 1'b0;
      bus.s_tvalid = 1'b0;
      repeat (3) @(negedge clk_50mhz);
      model_reset();
      reset_n = 1'b1;
      clear_data(); re_a[960] = 2048; full_order(-1);
      run_frame("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
      $finish;
   end
endmodule
